// File: rtl/trace_bank_stim.sv
`timescale 1ns/1ps
// trace_bank_stim: parametrised bank of INSTANCES x VARS generated state
// registers that advance each enabled cycle for a bounded run, with a
// registered XOR checksum over every register and a one-cycle finish pulse.
module trace_bank_stim #(
  parameter int INSTANCES = 10,
  parameter int VARS      = 10,
  parameter int WIDTH     = 1,
  parameter int MODE      = 0,
  parameter int CYCLES    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  output logic [$clog2(CYCLES+1)-1:0]     cycle_cnt,
  output logic [WIDTH-1:0]                checksum,
  output logic                            done,
  output logic                            finish
);

  localparam int CW    = $clog2(CYCLES + 1);
  localparam int NREGS = INSTANCES * VARS;
  localparam logic [CW-1:0] LAST_CNT = CW'(CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CYCLES);

  // Flattened view of every x[i][j]; slice (i*VARS+j) holds register x[i][j].
  logic [NREGS*WIDTH-1:0] x_flat;

  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] checksum_reg, checksum_next;
  logic             done_reg, done_next;
  logic             finish_reg, finish_next;
  logic             update;

  // An update happens only while the run is still in progress.
  assign update = en & ~done_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < INSTANCES; gi++) begin : g_inst
      for (gj = 0; gj < VARS; gj++) begin : g_var
        // Even-indexed variables start all-ones, odd-indexed start at zero.
        localparam logic [WIDTH-1:0] RST_VAL = ((gj % 2) == 0) ? '1 : '0;
        // Per-register increment, deliberately truncated to WIDTH bits.
        localparam logic [WIDTH-1:0] STEP    = WIDTH'(gi + gj + 1);

        logic [WIDTH-1:0] x_reg, x_next;

        // Update rule chosen at elaboration; unknown modes fall back to hold.
        if (MODE == 1) begin : g_inc
          always_comb x_next = update ? (x_reg + STEP) : x_reg;
        end else if (MODE == 2) begin : g_inv
          always_comb x_next = update ? ~x_reg : x_reg;
        end else begin : g_hold
          always_comb x_next = x_reg;
        end

        // State register for x[gi][gj].
        always_ff @(posedge clk) begin
          if (!rst_n) x_reg <= RST_VAL;
          else        x_reg <= x_next;
        end

        assign x_flat[(gi*VARS+gj)*WIDTH +: WIDTH] = x_reg;
      end
    end
  endgenerate

  // XOR-reduce all current (pre-update) register values.
  always_comb begin
    checksum_next = '0;
    for (int k = 0; k < NREGS; k++) begin
      checksum_next = checksum_next ^ x_flat[k*WIDTH +: WIDTH];
    end
  end

  // Run counter, sticky done, and the finish pulse that marks done rising.
  always_comb begin
    cnt_next    = cnt_reg;
    done_next   = done_reg;
    finish_next = 1'b0;
    if (update) begin
      cnt_next = (cnt_reg == FULL_CNT) ? cnt_reg : cnt_reg + 1'b1;
      if (cnt_reg == LAST_CNT) begin
        done_next   = 1'b1;
        finish_next = 1'b1;
      end
    end
  end

  // Control and checksum registers; reset wins over a simultaneous final update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      checksum_reg <= '0;
      done_reg     <= 1'b0;
      finish_reg   <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      checksum_reg <= checksum_next;
      done_reg     <= done_next;
      finish_reg   <= finish_next;
    end
  end

  assign cycle_cnt = cnt_reg;
  assign checksum  = checksum_reg;
  assign done      = done_reg;
  assign finish    = finish_reg;

endmodule

// File: tb/tb_trace_bank_stim.sv
`timescale 1ns/1ps
// Directed bench for trace_bank_stim: three configurations (default, invert,
// increment-with-wrap) share clock, reset and enable.
module tb_trace_bank_stim;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Default configuration: 10 x 10 x 1 bit, hold, 16 cycles.
  logic [4:0] cnt_def;
  logic [0:0] cks_def;
  logic       done_def, fin_def;

  trace_bank_stim u_def (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cycle_cnt(cnt_def), .checksum(cks_def), .done(done_def), .finish(fin_def)
  );

  // Invert configuration: 1 x 2 x 4 bits, CYCLES=3.
  logic [1:0] cnt_inv;
  logic [3:0] cks_inv;
  logic       done_inv, fin_inv;

  trace_bank_stim #(.INSTANCES(1), .VARS(2), .WIDTH(4), .MODE(2), .CYCLES(3)) u_inv (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cycle_cnt(cnt_inv), .checksum(cks_inv), .done(done_inv), .finish(fin_inv)
  );

  // Increment configuration: 1 x 2 x 4 bits, CYCLES=4.
  logic [2:0] cnt_inc;
  logic [3:0] cks_inc;
  logic       done_inc, fin_inc;

  trace_bank_stim #(.INSTANCES(1), .VARS(2), .WIDTH(4), .MODE(1), .CYCLES(4)) u_inc (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cycle_cnt(cnt_inc), .checksum(cks_inc), .done(done_inc), .finish(fin_inc)
  );

  // Advance one posedge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({cnt_inc, cks_inc, done_inc, fin_inc} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_inc: got cnt=%0d cks=%h done=%b fin=%b, want all 0",
               cnt_inc, cks_inc, done_inc, fin_inc);
    end
    n_cmp++;
    if ({cnt_def, cks_def, done_def, fin_def} !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_def: got cnt=%0d cks=%h done=%b fin=%b, want all 0",
               cnt_def, cks_def, done_def, fin_def);
    end
    rst_n = 1'b1;
    tick();
    $display("reset released: def cks=%h cnt=%0d, inc cks=%h", cks_def, cnt_def, cks_inc);
    n_cmp++;
    if (cks_def !== 1'b0 || cnt_def !== 5'd0 || done_def !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pattern_def: got cks=%h cnt=%0d done=%b, want cks=0 cnt=0 done=0",
               cks_def, cnt_def, done_def);
    end
    n_cmp++;
    if (cks_inc !== 4'hF || cnt_inc !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_pattern_inc: got cks=%h cnt=%0d, want cks=f cnt=0", cks_inc, cnt_inc);
    end
  endtask

  task automatic test_invert();
    logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       exp_done[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_fin [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("invert step %0d: cks=%h cnt=%0d done=%b fin=%b", k, cks_inv, cnt_inv, done_inv, fin_inv);
      n_cmp++;
      if (cks_inv !== 4'hF || cnt_inv !== exp_cnt[k] || done_inv !== exp_done[k] || fin_inv !== exp_fin[k]) begin
        n_bad++;
        $display("FAIL invert_step%0d: got cks=%h cnt=%0d done=%b fin=%b, want cks=f cnt=%0d done=%b fin=%b",
                 k, cks_inv, cnt_inv, done_inv, fin_inv, exp_cnt[k], exp_done[k], exp_fin[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_increment();
    logic [3:0] exp_cks [5] = '{4'hF, 4'h2, 4'h5, 4'h4, 4'hB};
    logic [2:0] exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       exp_done[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_fin [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("increment step %0d: cks=%h cnt=%0d done=%b fin=%b", k, cks_inc, cnt_inc, done_inc, fin_inc);
      n_cmp++;
      if (cks_inc !== exp_cks[k] || cnt_inc !== exp_cnt[k] || done_inc !== exp_done[k] || fin_inc !== exp_fin[k]) begin
        n_bad++;
        $display("FAIL increment_step%0d: got cks=%h cnt=%0d done=%b fin=%b, want cks=%h cnt=%0d done=%b fin=%b",
                 k, cks_inc, cnt_inc, done_inc, fin_inc, exp_cks[k], exp_cnt[k], exp_done[k], exp_fin[k]);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic       en_pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_cks [6] = '{4'hF, 4'h2, 4'h2, 4'h2, 4'h5, 4'h4};
    logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic       exp_done[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      en = en_pat[k];
      tick();
      $display("enable step %0d en=%b: cks=%h cnt=%0d done=%b", k, en_pat[k], cks_inc, cnt_inc, done_inc);
      n_cmp++;
      if (cks_inc !== exp_cks[k] || cnt_inc !== exp_cnt[k] || done_inc !== exp_done[k]) begin
        n_bad++;
        $display("FAIL enable_step%0d: got cks=%h cnt=%0d done=%b, want cks=%h cnt=%0d done=%b",
                 k, cks_inc, cnt_inc, done_inc, exp_cks[k], exp_cnt[k], exp_done[k]);
      end
    end
  endtask

  // Continues directly from the enable test with the increment bank done.
  task automatic test_post_done();
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      $display("post-done step %0d: cks=%h cnt=%0d done=%b fin=%b", k, cks_inc, cnt_inc, done_inc, fin_inc);
      n_cmp++;
      if (cks_inc !== 4'hB || cnt_inc !== 3'd4 || done_inc !== 1'b1 || fin_inc !== 1'b0) begin
        n_bad++;
        $display("FAIL post_done_step%0d: got cks=%h cnt=%0d done=%b fin=%b, want cks=b cnt=4 done=1 fin=0",
                 k, cks_inc, cnt_inc, done_inc, fin_inc);
      end
    end
    n_cmp++;
    if (cnt_inv !== 2'd3 || done_inv !== 1'b1 || fin_inv !== 1'b0) begin
      n_bad++;
      $display("FAIL post_done_inv: got cnt=%0d done=%b fin=%b, want cnt=3 done=1 fin=0",
               cnt_inv, done_inv, fin_inv);
    end
    en = 1'b0;
  endtask

  task automatic test_midrun_reset();
    logic [3:0] exp_cks [5] = '{4'hF, 4'h2, 4'h5, 4'h4, 4'hB};
    logic [2:0] exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    // Reset during the second update.
    apply_reset();
    en = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    $display("reset at update 2: cks=%h cnt=%0d done=%b", cks_inc, cnt_inc, done_inc);
    n_cmp++;
    if (cks_inc !== 4'h0 || cnt_inc !== 3'd0 || done_inc !== 1'b0 || fin_inc !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset_u2: got cks=%h cnt=%0d done=%b fin=%b, want all 0",
               cks_inc, cnt_inc, done_inc, fin_inc);
    end
    rst_n = 1'b1;
    // Run up to the final update, then reset on it.
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b0;
    tick();
    $display("reset at final update: cks=%h cnt=%0d done=%b fin=%b", cks_inc, cnt_inc, done_inc, fin_inc);
    n_cmp++;
    if (cks_inc !== 4'h0 || cnt_inc !== 3'd0 || done_inc !== 1'b0 || fin_inc !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset_final: got cks=%h cnt=%0d done=%b fin=%b, want all 0",
               cks_inc, cnt_inc, done_inc, fin_inc);
    end
    rst_n = 1'b1;
    // Full rerun reproduces the same sequence.
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("rerun step %0d: cks=%h cnt=%0d", k, cks_inc, cnt_inc);
      n_cmp++;
      if (cks_inc !== exp_cks[k] || cnt_inc !== exp_cnt[k]) begin
        n_bad++;
        $display("FAIL rerun_step%0d: got cks=%h cnt=%0d, want cks=%h cnt=%0d",
                 k, cks_inc, cnt_inc, exp_cks[k], exp_cnt[k]);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_invert();
    test_increment();
    test_enable_gating();
    test_post_done();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_bank_stim.md
# trace_bank_stim

Parametrised bank of generated per-instance state registers used as a tracing and trace-combine stimulus block. It instantiates INSTANCES sub-banks of VARS registers each, WIDTH bits wide, and advances them each enabled cycle according to MODE. The block runs a bounded number of cycles, then signals completion with a one-cycle finish pulse. A registered XOR checksum over every register lets the bench check behaviour without probing internal signals.

## Interface

- INSTANCES, 10, number of generated sub-banks (≥1)
- VARS, 10, registers per sub-bank (≥1)
- WIDTH, 1, bits per register (1..32)
- MODE, 0, update rule: 0 = hold, 1 = increment, 2 = invert
- CYCLES, 16, enabled cycles to run before done (≥1)

Ports:

- clk  input  1  single clock; all state updates on posedge clk
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  advance enable; sampled each posedge
- cycle_cnt  output  $clog2(CYCLES+1)  enabled cycles completed
- checksum  output  WIDTH  XOR of all INSTANCES*VARS registers, registered
- done  output  1  high once CYCLES enabled cycles have completed; sticky until reset
- finish  output  1  one-cycle pulse on the rising edge of done

## Operation

- Register x[i][j] has instance index i in 0..INSTANCES-1 and variable index j in 0..VARS-1.
- Reset pattern: x[i][j] = all-ones when j is even, and 0 when j is odd.
- An update occurs on a posedge with rst_n=1, en=1 and done=0. The update rule depends on MODE:
  - MODE 0: x holds its value.
  - MODE 1: x[i][j] <= x[i][j] + (i+j+1), truncated to WIDTH bits, wrapping modulo 2^WIDTH.
  - MODE 2: x[i][j] <= ~x[i][j].
- cycle_cnt increments by 1 on each update, in every MODE, including MODE 0.
- done is set on the update that takes cycle_cnt from CYCLES-1 to CYCLES.
- Once done=1:
  - no further updates occur;
  - cycle_cnt saturates at CYCLES;
  - en is ignored.
- finish = done & ~done_q, where done_q is done delayed by one cycle. It is high for exactly one cycle per run.
- On each posedge with rst_n=1, checksum <= XOR-reduce of the current x values (pre-update). Each term contributes all of its WIDTH bits.
- en low holds all state. checksum still refreshes and is stable because x does not change.
- Unsupported MODE values (3 and above) behave as MODE 0.

## Timing

- Reset (rst_n=0 at a posedge) sets:
  - x to the reset pattern;
  - cycle_cnt=0, checksum=0, done=0, finish=0, done_q=0.
- Reset asserted mid-run, including in the same cycle as the final update, wins over everything. The next cycle shows reset values.
- checksum latency is 1 cycle. The first posedge after reset release loads the reset-pattern checksum, and it then tracks x one cycle late.
- done is visible in the cycle after the CYCLES-th update. finish is high in that same cycle and low in the following one.
- The minimum run from reset release with en held high is CYCLES posedges to done=1.
- cycle_cnt, done and finish are all registered. There are no combinational paths from inputs to outputs.

## Test plan

- Reset-pattern checksum: defaults (INSTANCES=10, VARS=10, WIDTH=1, MODE 0). Release reset, en=0 → one cycle later checksum=0 (each sub-bank has 5 ones, 10 banks cancel); cycle_cnt=0; done=0.
- Invert mode: INSTANCES=1, VARS=2, WIDTH=4, MODE 2, CYCLES=3, en=1.
  - Checksum sequence: 0xF, 0xF, 0xF, 0xF.
  - done rises after the 3rd update; finish high for exactly 1 cycle.
  - cycle_cnt holds at 3 afterwards.
- Increment with wrap: INSTANCES=1, VARS=2, WIDTH=4, MODE 1, CYCLES=4, en=1.
  - x0: 0xF → 0x0 → 0x1 → 0x2 → 0x3.
  - x1: 0x0 → 0x2 → 0x4 → 0x6 → 0x8.
  - Checksum follows one cycle late: 0xF, 0x2, 0x5, 0x4, final 0xB.
- Enable gating: same config as the increment test, en pattern 1,0,0,1,1,1 → cycle_cnt 1,1,1,2,3,4; done only after the 6th posedge; x frozen while en=0.
- Post-done freeze: after done, hold en=1 for 10 more cycles → checksum, cycle_cnt and x unchanged; finish stays 0.
- Mid-run reset: assert rst_n=0 for 1 cycle during update 2 (and separately on the CYCLES-th update) → reset values on the next cycle, done stays 0, and a full rerun reproduces the identical checksum sequence.
